// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared FSM encoding and constants for the polyphonic tone sequencer
package tone_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Articulation gap is the last dur>>ART_SHIFT clocks of every note
  localparam int ART_SHIFT = 3;

  // Mixer accumulator width: holds acc + popcount without overflow
  function automatic int acc_bw(input int channels);
    return $clog2(channels + 1) + 1;
  endfunction

endpackage

// File: rtl/tone_seq_poly_if.sv
// rtl/tone_seq_poly_if.sv - note ROM bus between the sequencer and the external note ROM
interface tone_seq_poly_if #(
  parameter int CHANNELS = 2,
  parameter int DIV_BW   = 16,
  parameter int SEQ_BW   = 6
);

  logic [SEQ_BW-1:0]          note_index;
  logic [CHANNELS*DIV_BW-1:0] divider;

  modport master (output note_index, input divider);
  modport slave  (input note_index, output divider);

endinterface

// File: rtl/tone_voice.sv
// rtl/tone_voice.sv - one square-wave voice: period register, wrap counter, rest detect
module tone_voice
  import tone_pkg::*;
#(
  parameter int DIV_BW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              load,
  input  logic              run,
  input  logic              mute,
  input  logic [DIV_BW-1:0] divider,
  output logic              tone
);

  logic [DIV_BW-1:0] period;
  logic [DIV_BW-1:0] count;
  logic              rest;

  // Periods 0 and 1 cannot form a square wave, so they play as silence
  assign rest = (period < DIV_BW'(2));

  // Period latch on note load, free-running wrap counter while the note plays
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period <= '0;
      count  <= '0;
    end else if (ena) begin
      if (load) begin
        period <= divider;
        count  <= '0;
      end else if (run) begin
        if (rest || (count == period - 1'b1)) begin
          count <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

  // High for the first half of each period; the counter keeps running while muted
  assign tone = run && !mute && !rest && (count < (period >> 1));

endmodule

// File: rtl/tone_seq_poly.sv
// rtl/tone_seq_poly.sv - polyphonic note sequencer with sigma-delta voice mixer
module tone_seq_poly
  import tone_pkg::*;
#(
  parameter int              CHANNELS      = 2,
  parameter int              DIV_BW        = 16,
  parameter int              DUR_BW        = 24,
  parameter int              SEQ_BW        = 6,
  parameter logic [DUR_BW-1:0] NOTE_DURATION = 24'd2400000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                loop_i,
  input  logic [1:0]          tempo_sel_i,
  input  logic [SEQ_BW-1:0]   seq_len_i,
  tone_seq_poly_if.master     rom,
  output logic [CHANNELS-1:0] tone_o,
  output logic                mix_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int ACC_BW = acc_bw(CHANNELS);

  state_t              state;
  logic [SEQ_BW-1:0]   note_index;
  logic [SEQ_BW-1:0]   seq_len;
  logic [SEQ_BW-1:0]   last_index;
  logic [1:0]          tempo;
  logic [DUR_BW-1:0]   dur_cnt;
  logic [DUR_BW-1:0]   dur_raw;
  logic [DUR_BW-1:0]   dur;
  logic [DUR_BW-1:0]   mute_from;
  logic                strobe;
  logic                mute;
  logic [ACC_BW-1:0]   acc;
  logic [ACC_BW-1:0]   tone_count;
  logic [ACC_BW-1:0]   acc_sum;

  assign rom.note_index = note_index;

  // A length of 0 wraps to all-ones, i.e. the full 2**SEQ_BW sequence
  assign last_index = seq_len - 1'b1;

  // Faster tempos shorten the note; a zero duration still plays one cycle
  assign dur_raw   = NOTE_DURATION >> tempo;
  assign dur       = (dur_raw == '0) ? DUR_BW'(1) : dur_raw;
  assign mute_from = dur - (dur >> ART_SHIFT);
  assign strobe    = (state == ST_PLAY) && (dur_cnt == dur - 1'b1);
  assign mute      = (dur_cnt >= mute_from);

  // Sequencer FSM: stop beats start beats end-of-note strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      note_index <= '0;
      seq_len    <= '0;
      tempo      <= '0;
      dur_cnt    <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else if (ena) begin
      done_o <= 1'b0;
      if (stop_i) begin
        state  <= ST_IDLE;
        busy_o <= 1'b0;
      end else if (start_i) begin
        state      <= ST_LOAD;
        busy_o     <= 1'b1;
        note_index <= '0;
        seq_len    <= seq_len_i;
        tempo      <= tempo_sel_i;
      end else begin
        case (state)
          ST_LOAD: begin
            state   <= ST_PLAY;
            dur_cnt <= '0;
          end
          ST_PLAY: begin
            if (strobe) begin
              if (note_index != last_index) begin
                note_index <= note_index + 1'b1;
                state      <= ST_LOAD;
              end else if (loop_i) begin
                note_index <= '0;
                state      <= ST_LOAD;
              end else begin
                state  <= ST_DONE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
              end
            end else begin
              dur_cnt <= dur_cnt + 1'b1;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: ;
        endcase
      end
    end
  end

  // One voice per channel, each fed its own slice of the ROM word
  for (genvar c = 0; c < CHANNELS; c++) begin : g_voice
    tone_voice #(
      .DIV_BW (DIV_BW)
    ) u_voice (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .load    (state == ST_LOAD),
      .run     (state == ST_PLAY),
      .mute    (mute),
      .divider (rom.divider[c*DIV_BW +: DIV_BW]),
      .tone    (tone_o[c])
    );
  end

  // Count how many voices are currently high
  always_comb begin
    tone_count = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      tone_count = tone_count + ACC_BW'(tone_o[c]);
    end
  end

  assign acc_sum = acc + tone_count;

  // First-order sigma-delta: output density tracks popcount/CHANNELS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      mix_o <= 1'b0;
    end else if (ena) begin
      if (acc_sum >= ACC_BW'(CHANNELS)) begin
        mix_o <= 1'b1;
        acc   <= acc_sum - ACC_BW'(CHANNELS);
      end else begin
        mix_o <= 1'b0;
        acc   <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_tone_seq_poly.sv
// tb/tb_tone_seq_poly.sv - directed self-checking bench for tone_seq_poly
module tb_tone_seq_poly;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop_en = 1'b0;
  logic [1:0] tempo_sel = 2'd0;
  logic [2:0] seq_len = 3'd0;
  logic [1:0] tone;
  logic       mix;
  logic       busy;
  logic       done;
  logic [15:0] rom_data [0:7];

  int checks = 0;
  int errors = 0;

  tone_seq_poly_if #(.CHANNELS(2), .DIV_BW(8), .SEQ_BW(3)) rom_bus ();

  assign rom_bus.divider = rom_data[rom_bus.note_index];

  tone_seq_poly #(
    .CHANNELS      (2),
    .DIV_BW        (8),
    .DUR_BW        (24),
    .SEQ_BW        (3),
    .NOTE_DURATION (24'd16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .start_i     (start),
    .stop_i      (stop),
    .loop_i      (loop_en),
    .tempo_sel_i (tempo_sel),
    .seq_len_i   (seq_len),
    .rom         (rom_bus),
    .tone_o      (tone),
    .mix_o       (mix),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [2:0] len, input logic [1:0] tsel, input logic lp);
    seq_len   = len;
    tempo_sel = tsel;
    loop_en   = lp;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic go_idle();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ena   = 1'b1;
    #12;
    checks++; if (tone !== 2'b00) begin errors++; $display("FAIL reset_tone got %b exp 00", tone); end
    checks++; if (mix !== 1'b0) begin errors++; $display("FAIL reset_mix got %b exp 0", mix); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (rom_bus.note_index !== 3'd0) begin errors++; $display("FAIL reset_index got %0d exp 0", rom_bus.note_index); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_sequence();
    logic [2:0] exp_idx;
    for (int i = 0; i < 8; i++) rom_data[i] = {8'd8, 8'd4};
    pulse_start(3'd3, 2'd0, 1'b0);
    for (int s = 1; s <= 60; s++) begin
      if (s > 1) step();
      exp_idx = (s <= 17) ? 3'd0 : (s <= 34) ? 3'd1 : 3'd2;
      checks++; if (rom_bus.note_index !== exp_idx) begin errors++; $display("FAIL seq_index step %0d got %0d exp %0d", s, rom_bus.note_index, exp_idx); end
      checks++; if (busy !== (s <= 51)) begin errors++; $display("FAIL seq_busy step %0d got %b exp %b", s, busy, (s <= 51)); end
      checks++; if (done !== (s == 52)) begin errors++; $display("FAIL seq_done step %0d got %b exp %b", s, done, (s == 52)); end
    end
  endtask

  task automatic test_voice_pattern();
    logic exp0;
    int k;
    rom_data[0] = {8'd1, 8'd4};
    pulse_start(3'd1, 2'd0, 1'b0);
    for (int s = 1; s <= 20; s++) begin
      if (s > 1) step();
      k = s - 2;
      exp0 = (s >= 2) && (s <= 17) && (k < 14) && ((k % 4) < 2);
      checks++; if (tone !== {1'b0, exp0}) begin errors++; $display("FAIL voice_pattern step %0d got %b exp %b", s, tone, {1'b0, exp0}); end
    end
  endtask

  task automatic test_rest();
    rom_data[0] = {8'd1, 8'd0};
    pulse_start(3'd1, 2'd0, 1'b0);
    for (int s = 1; s <= 18; s++) begin
      if (s > 1) step();
      checks++; if (tone !== 2'b00) begin errors++; $display("FAIL rest_tone step %0d got %b exp 00", s, tone); end
      checks++; if (busy !== (s <= 17)) begin errors++; $display("FAIL rest_busy step %0d got %b exp %b", s, busy, (s <= 17)); end
    end
  endtask

  task automatic test_loop();
    logic [2:0] exp_idx;
    rom_data[0] = {8'd8, 8'd4};
    rom_data[1] = {8'd4, 8'd8};
    pulse_start(3'd2, 2'd0, 1'b1);
    for (int s = 1; s <= 104; s++) begin
      if (s > 1) step();
      exp_idx = (s <= 102) ? 3'(((s - 1) / 17) % 2) : 3'd1;
      checks++; if (rom_bus.note_index !== exp_idx) begin errors++; $display("FAIL loop_index step %0d got %0d exp %0d", s, rom_bus.note_index, exp_idx); end
      checks++; if (done !== (s == 103)) begin errors++; $display("FAIL loop_done step %0d got %b exp %b", s, done, (s == 103)); end
      if (s == 90) loop_en = 1'b0;
    end
  endtask

  task automatic test_stop_restart();
    for (int i = 0; i < 8; i++) rom_data[i] = {8'd8, 8'd4};
    pulse_start(3'd3, 2'd0, 1'b0);
    for (int s = 2; s <= 6; s++) step();
    checks++; if (tone[0] !== 1'b1) begin errors++; $display("FAIL stop_pre_tone got %b exp 1", tone[0]); end
    stop  = 1'b1;
    start = 1'b1;
    step();
    stop  = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy cycle %0d got %b exp 0", i, busy); end
      checks++; if (tone !== 2'b00) begin errors++; $display("FAIL stop_tone cycle %0d got %b exp 00", i, tone); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop_done cycle %0d got %b exp 0", i, done); end
      step();
    end
    pulse_start(3'd3, 2'd0, 1'b0);
    for (int s = 2; s <= 24; s++) step();
    checks++; if (rom_bus.note_index !== 3'd1) begin errors++; $display("FAIL restart_pre_index got %0d exp 1", rom_bus.note_index); end
    pulse_start(3'd3, 2'd0, 1'b0);
    checks++; if (rom_bus.note_index !== 3'd0) begin errors++; $display("FAIL restart_index got %0d exp 0", rom_bus.note_index); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy got %b exp 1", busy); end
    checks++; if (tone !== 2'b00) begin errors++; $display("FAIL restart_load_tone got %b exp 00", tone); end
    for (int i = 0; i < 16; i++) step();
    checks++; if (rom_bus.note_index !== 3'd0) begin errors++; $display("FAIL restart_hold_index got %0d exp 0", rom_bus.note_index); end
    step();
    checks++; if (rom_bus.note_index !== 3'd1) begin errors++; $display("FAIL restart_next_index got %0d exp 1", rom_bus.note_index); end
    go_idle();
  endtask

  task automatic test_mix_ena();
    logic exp_mix;
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rom_data[0] = {8'd200, 8'd200};
    pulse_start(3'd1, 2'd0, 1'b0);
    for (int s = 1; s <= 20; s++) begin
      if (s > 1) step();
      exp_mix = (s >= 3) && (s <= 16);
      checks++; if (mix !== exp_mix) begin errors++; $display("FAIL mix_both step %0d got %b exp %b", s, mix, exp_mix); end
    end
    rom_data[0] = {8'd0, 8'd200};
    pulse_start(3'd1, 2'd0, 1'b0);
    for (int s = 1; s <= 8; s++) begin
      if (s > 1) step();
      exp_mix = (s >= 3) && ((s % 2) == 0);
      checks++; if (mix !== exp_mix) begin errors++; $display("FAIL mix_one step %0d got %b exp %b", s, mix, exp_mix); end
    end
    ena   = 1'b0;
    start = 1'b1;
    stop  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (tone !== 2'b01) begin errors++; $display("FAIL freeze_tone cycle %0d got %b exp 01", i, tone); end
      checks++; if (mix !== 1'b1) begin errors++; $display("FAIL freeze_mix cycle %0d got %b exp 1", i, mix); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL freeze_busy cycle %0d got %b exp 1", i, busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL freeze_done cycle %0d got %b exp 0", i, done); end
      checks++; if (rom_bus.note_index !== 3'd0) begin errors++; $display("FAIL freeze_index cycle %0d got %0d exp 0", i, rom_bus.note_index); end
    end
    start = 1'b0;
    stop  = 1'b0;
    ena   = 1'b1;
    step();
    checks++; if (mix !== 1'b0) begin errors++; $display("FAIL resume_mix0 got %b exp 0", mix); end
    checks++; if (tone !== 2'b01) begin errors++; $display("FAIL resume_tone got %b exp 01", tone); end
    step();
    checks++; if (mix !== 1'b1) begin errors++; $display("FAIL resume_mix1 got %b exp 1", mix); end
    go_idle();
  endtask

  task automatic test_tempo_reset();
    logic [2:0] exp_idx;
    logic       exp0;
    rom_data[0] = {8'd8, 8'd4};
    rom_data[1] = {8'd8, 8'd4};
    pulse_start(3'd2, 2'd2, 1'b0);
    for (int s = 1; s <= 12; s++) begin
      if (s > 1) step();
      exp_idx = (s <= 5) ? 3'd0 : 3'd1;
      checks++; if (rom_bus.note_index !== exp_idx) begin errors++; $display("FAIL tempo_index step %0d got %0d exp %0d", s, rom_bus.note_index, exp_idx); end
      checks++; if (done !== (s == 11)) begin errors++; $display("FAIL tempo_done step %0d got %b exp %b", s, done, (s == 11)); end
      checks++; if (busy !== (s <= 10)) begin errors++; $display("FAIL tempo_busy step %0d got %b exp %b", s, busy, (s <= 10)); end
      if (s >= 2 && s <= 5) begin
        exp0 = (s <= 3);
        checks++; if (tone[0] !== exp0) begin errors++; $display("FAIL tempo_tone step %0d got %b exp %b", s, tone[0], exp0); end
      end
    end
    pulse_start(3'd2, 2'd2, 1'b0);
    for (int s = 2; s <= 8; s++) step();
    checks++; if (rom_bus.note_index !== 3'd1) begin errors++; $display("FAIL areset_pre_index got %0d exp 1", rom_bus.note_index); end
    checks++; if (tone !== 2'b11) begin errors++; $display("FAIL areset_pre_tone got %b exp 11", tone); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (tone !== 2'b00) begin errors++; $display("FAIL areset_tone got %b exp 00", tone); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b exp 0", busy); end
    checks++; if (mix !== 1'b0) begin errors++; $display("FAIL areset_mix got %b exp 0", mix); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL areset_done got %b exp 0", done); end
    checks++; if (rom_bus.note_index !== 3'd0) begin errors++; $display("FAIL areset_index got %0d exp 0", rom_bus.note_index); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom_data[i] = 16'd0;
    test_reset();
    test_sequence();
    test_voice_pattern();
    test_rest();
    test_loop();
    test_stop_restart();
    test_mix_ena();
    test_tempo_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
